// File: rtl/rst_seq_pkg.sv
// Shared definitions for the rst_seq reset sequencer: FSM state encoding,
// loss-counter width and a counter-width helper.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    HOLD      = 2'd1,
    REL       = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rst_seq_if.sv
// Signal bundle between a clock domain's reset consumers and rst_seq.
// The master drives lock and software requests; the slave (rst_seq) drives resets and status.
interface rst_seq_if #(parameter int N_CH = 2);
  import rst_seq_pkg::*;

  // sw_rst_req is a one-cycle pulse with no back-pressure: a request is either
  // acted on at the edge it is sampled or dropped, and never held over.
  logic                  pll_lock;
  logic [N_CH-1:0]       sw_rst_req;
  logic [N_CH-1:0]       rst_out;
  logic                  ready;
  logic                  lock_lost;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  state_t                state_dbg;

  modport master (
    output pll_lock, sw_rst_req,
    input  rst_out, ready, lock_lost, loss_cnt, state_dbg
  );

  modport slave (
    input  pll_lock, sw_rst_req,
    output rst_out, ready, lock_lost, loss_cnt, state_dbg
  );

endinterface

// File: rtl/rst_seq_sync.sv
// Parametrised multi-flop synchroniser for slow asynchronous level signals.
// Flops carry no reset so the chain keeps tracking the input while the domain is in reset.
module rst_seq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] ff [STAGES];

    always_ff @(posedge clk) begin
        ff[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            ff[i] <= ff[i-1];
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: qualifies PLL lock, holds reset, then releases channels in order.
// Define RST_SEQ_LOSS_CNT_EN to build the saturating lock-loss event counter.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int LOCK_FILTER = 16,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4
) (
    input logic       clk,
    input logic       rst,
    rst_seq_if.slave  bus
);

    localparam int FILT_W = cnt_w(LOCK_FILTER);
    localparam int HOLD_W = cnt_w(HOLD_CYCLES);
    localparam int GAP_W  = cnt_w(GAP_CYCLES);
    localparam int REL_W  = $clog2(N_CH + 1);

    state_t            state;
    logic [FILT_W-1:0] filt_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [GAP_W-1:0]  gap_cnt;
    logic [REL_W-1:0]  rel_cnt;
    logic [N_CH-1:0]   rst_out_q;
    logic              ready_q;
    logic              lock_lost_q;
    logic              lock_s;
    logic              sw_any;
    logic [REL_W-1:0]  sw_idx;
    logic              sw_hit;

    rst_seq_sync #(.WIDTH(1), .STAGES(2)) u_lock_sync (
        .clk (clk),
        .d   (bus.pll_lock),
        .q   (lock_s)
    );

    // Channels at or above n are still held in reset.
    function automatic logic [N_CH-1:0] rel_mask(input int n);
        logic [N_CH-1:0] m;
        for (int i = 0; i < N_CH; i++) begin
            m[i] = (i >= n);
        end
        return m;
    endfunction

    always_comb begin
        sw_any = 1'b0;
        sw_idx = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (bus.sw_rst_req[i]) begin
                sw_any = 1'b1;
                sw_idx = REL_W'(i);
            end
        end
        sw_hit = sw_any && (state == REL || state == RUN) && (sw_idx < rel_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= WAIT_LOCK;
            filt_cnt    <= '0;
            hold_cnt    <= '0;
            gap_cnt     <= '0;
            rel_cnt     <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b0;
        end else if (state == WAIT_LOCK) begin
            if (!lock_s) begin
                filt_cnt <= '0;
            end else if (int'(filt_cnt) == LOCK_FILTER - 1) begin
                filt_cnt <= '0;
                hold_cnt <= '0;
                state    <= HOLD;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end else if (!lock_s) begin
            state       <= WAIT_LOCK;
            filt_cnt    <= '0;
            rel_cnt     <= '0;
            rst_out_q   <= '1;
            ready_q     <= 1'b0;
            lock_lost_q <= 1'b1;
        end else if (sw_hit) begin
            // Pull the release point back to the requested channel; later ones follow it.
            state     <= REL;
            rel_cnt   <= sw_idx;
            gap_cnt   <= '0;
            rst_out_q <= rel_mask(int'(sw_idx));
            ready_q   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (int'(hold_cnt) == HOLD_CYCLES - 1) begin
                        rel_cnt   <= REL_W'(1);
                        gap_cnt   <= '0;
                        rst_out_q <= rel_mask(1);
                        if (N_CH == 1) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state   <= REL;
                        end
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                REL: begin
                    if (int'(gap_cnt) == GAP_CYCLES - 1) begin
                        gap_cnt   <= '0;
                        rel_cnt   <= rel_cnt + REL_W'(1);
                        rst_out_q <= rel_mask(int'(rel_cnt) + 1);
                        if (int'(rel_cnt) + 1 == N_CH) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef RST_SEQ_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q;
    logic                  loss_evt;

    assign loss_evt = (state != WAIT_LOCK) && !lock_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else if (loss_evt && (loss_cnt_q != '1)) begin
            loss_cnt_q <= loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    assign bus.loss_cnt = loss_cnt_q;
`else
    assign bus.loss_cnt = '0;
`endif

    assign bus.rst_out   = rst_out_q;
    assign bus.ready     = ready_q;
    assign bus.lock_lost = lock_lost_q;
    assign bus.state_dbg = state;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq (N_CH=3, LOCK_FILTER=4, HOLD=8, GAP=2): release table,
// hand-written corner sequences and random lock/request traffic against a release-time model.
module tb_rst_seq;
  import rst_seq_pkg::*;

  localparam int N   = 3;
  localparam int LF  = 4;
  localparam int HC  = 8;
  localparam int GC  = 2;
  localparam int W   = N + 2 + LOSS_CNT_W;
  localparam int INF = 1 << 30;
`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  rst_seq_if #(.N_CH(N)) bus ();

  rst_seq #(
    .N_CH(N), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int edge_no = 0;

  // ---------------- reference model ----------------
  // Each channel has an absolute release edge; it is out of reset once that edge has passed.
  int  now = 0;
  bit  m_h1 = 1'b1, m_h2 = 1'b1;
  bit  qual = 1'b0;
  int  hi_run = 0;
  int  rel_at[N];
  bit  m_lost = 1'b0;
  int  m_loss = 0;
  logic [W-1:0] exp_q[$];

  task automatic model_edge();
    bit ls;
    int j;
    logic [N-1:0] ro;
    logic rdy;
    logic [LOSS_CNT_W-1:0] lc;
    ls   = m_h2;
    m_h2 = m_h1;
    m_h1 = bus.pll_lock;
    now++;
    if (rst) begin
      qual = 0; hi_run = 0; m_lost = 0; m_loss = 0;
      for (int k = 0; k < N; k++) rel_at[k] = INF;
    end else if (!qual) begin
      if (ls) begin
        hi_run++;
        if (hi_run == LF) begin
          qual = 1; hi_run = 0;
          for (int k = 0; k < N; k++) rel_at[k] = now + HC + k * GC;
        end
      end else begin
        hi_run = 0;
      end
    end else if (!ls) begin
      qual = 0; hi_run = 0; m_lost = 1;
      if (m_loss < 255) m_loss++;
      for (int k = 0; k < N; k++) rel_at[k] = INF;
    end else if (bus.sw_rst_req != '0) begin
      j = 0;
      for (int k = N - 1; k >= 0; k--) if (bus.sw_rst_req[k]) j = k;
      if (rel_at[0] < now && rel_at[j] < now)
        for (int k = j; k < N; k++) rel_at[k] = now + (k - j + 1) * GC;
    end
    for (int k = 0; k < N; k++) ro[k] = !(rel_at[k] <= now);
    rdy = (ro == '0);
    lc  = LOSS_EN ? LOSS_CNT_W'(m_loss) : '0;
    exp_q.push_back({m_lost, rdy, lc, ro});
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", name, act, exp, edge_no);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic lk, input logic [N-1:0] sw);
    logic [W-1:0] e, a;
    bus.pll_lock   = lk;
    bus.sw_rst_req = sw;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    e = exp_q.pop_front();
    a = {bus.lock_lost, bus.ready, bus.loss_cnt, bus.rst_out};
    check("scoreboard", 32'(a), 32'(e));
    edge_no++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) step(1'b1, '0);
    check("reset_rst_out", 32'(bus.rst_out), 32'h7);
    check("reset_ready", 32'(bus.ready), 0);
    check("reset_lock_lost", 32'(bus.lock_lost), 0);
    check("reset_loss_cnt", 32'(bus.loss_cnt), 0);
    check("reset_state", 32'(bus.state_dbg), 32'(WAIT_LOCK));
    rst = 1'b0;
    edge_no = 0;
  endtask

  typedef struct {
    int           edge_i;
    logic [N-1:0] rst_o;
    logic         rdy;
  } vec_t;

  vec_t tbl[6];

  task automatic run_seq(input int glitch_edge, input int off);
    for (int e = 0; e < 20; e++) begin
      step((e == glitch_edge) ? 1'b0 : 1'b1, '0);
      for (int t = 0; t < 6; t++) begin
        if (tbl[t].edge_i + off == e) begin
          check("table_rst_out", 32'(bus.rst_out), 32'(tbl[t].rst_o));
          check("table_ready", 32'(bus.ready), 32'(tbl[t].rdy));
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic lk;
    logic [N-1:0] sw;

    tbl[0] = '{10, 3'b111, 1'b0};
    tbl[1] = '{11, 3'b110, 1'b0};
    tbl[2] = '{12, 3'b110, 1'b0};
    tbl[3] = '{13, 3'b100, 1'b0};
    tbl[4] = '{14, 3'b100, 1'b0};
    tbl[5] = '{15, 3'b000, 1'b1};

    bus.pll_lock   = 1'b1;
    bus.sw_rst_req = '0;

    // basic sequencing
    do_reset();
    run_seq(-1, 0);

    // one-cycle lock glitch before qualification delays everything by 3 edges
    do_reset();
    run_seq(0, 3);
    check("glitch_no_lock_lost", 32'(bus.lock_lost), 0);

    // lock loss in RUN, then full re-lock
    step(1'b0, '0);
    step(1'b0, '0);
    check("ready_before_loss", 32'(bus.ready), 1);
    step(1'b0, '0);
    check("loss_rst_out", 32'(bus.rst_out), 32'h7);
    check("loss_ready", 32'(bus.ready), 0);
    check("loss_lock_lost", 32'(bus.lock_lost), 1);
    check("loss_cnt_1", 32'(bus.loss_cnt), LOSS_EN ? 1 : 0);
    repeat (20) step(1'b1, '0);
    check("relock_ready", 32'(bus.ready), 1);
    check("relock_rst_out", 32'(bus.rst_out), 0);

    // software reset of channel 1 in RUN
    step(1'b1, 3'b010);
    check("sw_assert", 32'(bus.rst_out), 32'h6);
    check("sw_ready_low", 32'(bus.ready), 0);
    step(1'b1, '0);
    check("sw_hold1", 32'(bus.rst_out), 32'h6);
    step(1'b1, '0);
    check("sw_ch1_rel", 32'(bus.rst_out), 32'h4);
    step(1'b1, '0);
    step(1'b1, '0);
    check("sw_ch2_rel", 32'(bus.rst_out), 32'h0);
    check("sw_ready_back", 32'(bus.ready), 1);

    // sw request on the same edge lock_s drops: loss wins
    step(1'b0, '0);
    step(1'b0, '0);
    step(1'b0, 3'b001);
    check("simul_rst_out", 32'(bus.rst_out), 32'h7);
    check("simul_loss_cnt", 32'(bus.loss_cnt), LOSS_EN ? 2 : 0);

    // request above rel_cnt is ignored
    n = 0;
    while (bus.rst_out !== 3'b110 && n < 40) begin
      step(1'b1, '0);
      n++;
    end
    check("relock_ch0", 32'(bus.rst_out), 32'h6);
    step(1'b1, 3'b100);
    check("sw_ignored", 32'(bus.rst_out), 32'h6);
    step(1'b1, '0);
    check("ch1_after_ignored", 32'(bus.rst_out), 32'h4);

    // many loss events: counter saturates
    repeat (300) begin
      repeat (6) step(1'b1, '0);
      repeat (4) step(1'b0, '0);
    end
    check("loss_cnt_sat", 32'(bus.loss_cnt), LOSS_EN ? 255 : 0);
    check("loss_sticky", 32'(bus.lock_lost), 1);

    // random lock drops and software requests
    do_reset();
    lk = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (lk) lk = ($urandom_range(0, 59) != 0);
      else    lk = ($urandom_range(0, 2) == 0);
      sw = ($urandom_range(0, 7) == 0) ? N'($urandom_range(1, 7)) : '0;
      step(lk, sw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
